// File: rtl/tristate_bus_receiver_pkg.sv
// Shared definitions for the three-state bus receiver: FSM state encoding
// and a counter-width helper.
package tristate_bus_receiver_pkg;

  localparam logic [1:0] ST_LISTEN = 2'd0;
  localparam logic [1:0] ST_OWN    = 2'd1;
  localparam logic [1:0] ST_TURN   = 2'd2;

  // Bits needed to hold every value 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((max_val >> w) != 0) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/tristate_bus_receiver_sync_ff.sv
// N-flop synchroniser with a configurable reset value, used on the raw
// bus read-back.
module sync_ff #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_reg <= {N{RESET_VAL}};
    end else begin
      chain_reg <= {chain_reg[N-2:0], d};
    end
  end

  assign q = chain_reg[N-1];

endmodule

// File: rtl/tristate_bus_receiver.sv
// Receive side of a shared three-state line: synchronise, glitch-filter and
// suppress the local echo. Optional edge pulses: TRISTATE_BUS_RX_EDGE_DET_EN.
module tristate_bus_receiver
  import tristate_bus_receiver_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter int   TURNAROUND  = 3,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_in,
  input  logic oe_local,
  output logic rx_data,
  output logic rx_valid,
  output logic rx_rise,
  output logic rx_fall
);

  localparam int TURN_W = cnt_width(TURNAROUND);
  localparam int FILT_W = cnt_width(FILTER_LEN - 1);

  logic              sync_q;
  logic [1:0]        state_reg, state_next;
  logic [TURN_W-1:0] turn_cnt_reg, turn_cnt_next;
  logic [FILT_W-1:0] filt_cnt_reg, filt_cnt_next;
  logic              rx_data_reg, rx_data_next;

  sync_ff #(
    .N         (SYNC_STAGES),
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus_in),
    .q   (sync_q)
  );

  always_comb begin
    state_next    = state_reg;
    turn_cnt_next = turn_cnt_reg;
    filt_cnt_next = '0;
    rx_data_next  = rx_data_reg;
    case (state_reg)
      ST_LISTEN: begin
        if (oe_local) begin
          state_next = ST_OWN;
        end else if (sync_q != rx_data_reg) begin
          // Only a run of FILTER_LEN differing samples moves the output.
          if (filt_cnt_reg == FILT_W'(FILTER_LEN - 1)) begin
            rx_data_next = sync_q;
          end else begin
            filt_cnt_next = filt_cnt_reg + 1'b1;
          end
        end
      end
      ST_OWN: begin
        if (!oe_local) begin
          state_next    = ST_TURN;
          turn_cnt_next = TURN_W'(TURNAROUND);
        end
      end
      ST_TURN: begin
        if (oe_local) begin
          state_next = ST_OWN;
        end else if (turn_cnt_reg == TURN_W'(1)) begin
          // Re-seed from the line so stale pre-drive data is never reported.
          state_next   = ST_LISTEN;
          rx_data_next = sync_q;
        end else begin
          turn_cnt_next = turn_cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next    = ST_TURN;
        turn_cnt_next = TURN_W'(TURNAROUND);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_TURN;
      turn_cnt_reg <= TURN_W'(TURNAROUND);
      filt_cnt_reg <= '0;
      rx_data_reg  <= IDLE_LEVEL;
    end else begin
      state_reg    <= state_next;
      turn_cnt_reg <= turn_cnt_next;
      filt_cnt_reg <= filt_cnt_next;
      rx_data_reg  <= rx_data_next;
    end
  end

  assign rx_data  = rx_data_reg;
  assign rx_valid = (state_reg == ST_LISTEN);

`ifdef TRISTATE_BUS_RX_EDGE_DET_EN
  logic prev_data_reg, prev_listen_reg, rise_reg, fall_reg;

  // A change counts as an edge only if it happened while already listening,
  // which excludes the re-seed on the TURN->LISTEN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_data_reg   <= IDLE_LEVEL;
      prev_listen_reg <= 1'b0;
      rise_reg        <= 1'b0;
      fall_reg        <= 1'b0;
    end else begin
      prev_data_reg   <= rx_data_reg;
      prev_listen_reg <= (state_reg == ST_LISTEN);
      rise_reg        <= prev_listen_reg && !prev_data_reg && rx_data_reg;
      fall_reg        <= prev_listen_reg && prev_data_reg && !rx_data_reg;
    end
  end

  assign rx_rise = rise_reg;
  assign rx_fall = fall_reg;
`else
  assign rx_rise = 1'b0;
  assign rx_fall = 1'b0;
`endif

endmodule

// File: tb/tb_tristate_bus_receiver.sv
// Directed self-checking bench for tristate_bus_receiver at default parameters.
// Observed/expected vectors are packed as {rx_data, rx_valid, rx_rise, rx_fall}.
module tb_tristate_bus_receiver;

  localparam bit EDGE_EN =
`ifdef TRISTATE_BUS_RX_EDGE_DET_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst, bus_in, oe_local;
  logic rx_data, rx_valid, rx_rise, rx_fall;
  logic [3:0] obs, exp_v;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tristate_bus_receiver dut (
    .clk      (clk),
    .rst      (rst),
    .bus_in   (bus_in),
    .oe_local (oe_local),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_rise  (rx_rise),
    .rx_fall  (rx_fall)
  );

  assign obs = {rx_data, rx_valid, rx_rise, rx_fall};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the edge that sampled rst=1 (that edge is edge 1).
  task automatic check_release(input string name);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      exp_v = {1'b1, (k >= 4), 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL %s edge=%0d got=%b want=%b", name, k, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; oe_local = 1'b0; bus_in = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    check_release("reset_release");
  endtask

  task automatic test_filter_edge(input logic new_level);
    bus_in = new_level;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_v = {(k >= 6) ? new_level : ~new_level, 1'b1,
               EDGE_EN && (k == 7) && new_level,
               EDGE_EN && (k == 7) && !new_level};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL filter_to_%b edge=%0d got=%b want=%b", new_level, k, obs, exp_v);
      end
    end
  endtask

  task automatic test_glitch(input int len);
    logic d;
    for (int k = 1; k <= 14; k++) begin
      bus_in = (k <= len) ? 1'b0 : 1'b1;
      tick();
      // A 4-sample glitch reaches rx_data at edge 6 and recovers at edge 10.
      d = (len >= 4 && k >= 6 && k <= 9) ? 1'b0 : 1'b1;
      exp_v = {d, 1'b1, EDGE_EN && len >= 4 && k == 11, EDGE_EN && len >= 4 && k == 7};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL glitch_len%0d edge=%0d got=%b want=%b", len, k, obs, exp_v);
      end
    end
  endtask

  task automatic test_own_echo();
    oe_local = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus_in = ~bus_in;
      tick();
      exp_v = 4'b1000;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL own_echo edge=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
    oe_local = 1'b0; bus_in = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_v = {(k >= 4) ? 1'b0 : 1'b1, (k >= 4), 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL own_turnaround edge=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_turn_abort();
    oe_local = 1'b1; tick();
    oe_local = 1'b0; tick(); tick();
    oe_local = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_v = 4'b0000;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL turn_abort edge=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
    oe_local = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_v = {1'b0, (k >= 4), 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL turn_restart edge=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus_in = 1'b1;
    check_release("rst_mid");
  endtask

  initial begin
    test_reset();
    test_filter_edge(1'b0);
    test_filter_edge(1'b1);
    test_glitch(3);
    test_glitch(4);
    test_own_echo();
    test_turn_abort();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
